// File: rtl/bullet_scheduler_if.sv
// Register-write bus between the bullet scheduler and the VGA ball display peripheral.
interface bullet_scheduler_if;
    logic [4:0] av_address;
    logic [7:0] av_writedata;
    logic       av_write;
    logic       av_chipselect;
    logic       bus_ready;

    modport master (
        output av_address,
        output av_writedata,
        output av_write,
        output av_chipselect,
        input  bus_ready
    );

    modport slave (
        input  av_address,
        input  av_writedata,
        input  av_write,
        input  av_chipselect,
        output bus_ready
    );
endinterface

// File: rtl/bullet_scheduler.sv
// Per-frame bullet controller: advances, retires and spawns bullets, then streams
// the whole bullet register image to the display peripheral.
module bullet_scheduler #(
    parameter int MAX_BULLETS  = 5,
    parameter int BULLET_SPEED = 8,
    parameter int X_LIMIT      = 1280,
    parameter int SHIP_W       = 40,
    parameter int SPAWN_DY     = 13,
    parameter int BULLET_BASE  = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   fire,
    input  logic [10:0]            ship_x,
    input  logic [9:0]             ship_y,
    bullet_scheduler_if.master     bus,
    output logic [MAX_BULLETS-1:0] bullet_active,
    output logic                   busy,
    output logic                   fire_dropped,
    output logic                   frame_overrun
);
    localparam int IDX_W    = $clog2(MAX_BULLETS);
    localparam int N_WRITES = 4 * MAX_BULLETS + 1;
    localparam int WCNT_W   = $clog2(N_WRITES);

    typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_ALLOC, ST_WRITE} state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic [WCNT_W-1:0]      wcnt_r;
    logic [10:0]            x_r [MAX_BULLETS];
    logic [9:0]             y_r [MAX_BULLETS];
    logic [MAX_BULLETS-1:0] active_r;
    logic                   pend_r;
    logic                   av_write_r;
    logic [4:0]             av_address_r;
    logic [7:0]             av_writedata_r;
    logic                   busy_r;
    logic                   fire_dropped_r;
    logic                   frame_overrun_r;

    logic [10:0]            x_nxt_s [MAX_BULLETS];
    logic [9:0]             y_nxt_s [MAX_BULLETS];
    logic [MAX_BULLETS-1:0] act_nxt_s;
    logic [11:0]            step_s;
    logic [11:0]            spawn_x_s;
    logic [IDX_W-1:0]       free_idx_s;
    logic                   free_ok_s;
    logic                   spawn_ok_s;

    // Register-image byte for write number n: four bytes per slot, then the bitmap.
    function automatic logic [7:0] word_f(
        input logic [WCNT_W-1:0]      n,
        input logic [10:0]            xs [MAX_BULLETS],
        input logic [9:0]             ys [MAX_BULLETS],
        input logic [MAX_BULLETS-1:0] act
    );
        logic [WCNT_W-3:0] k;
        logic [7:0]        w;
        k = n[WCNT_W-1:2];
        if (n >= WCNT_W'(4 * MAX_BULLETS)) begin
            w = 8'(act);
        end else begin
            case (n[1:0])
                2'd0:    w = xs[k][7:0];
                2'd1:    w = {5'd0, xs[k][10:8]};
                2'd2:    w = ys[k][7:0];
                2'd3:    w = {6'd0, ys[k][9:8]};
                default: w = 8'd0;
            endcase
        end
        return w;
    endfunction

    // Next bullet image: move/retire in UPDATE, spawn into the lowest free slot in ALLOC.
    always_comb begin
        x_nxt_s    = x_r;
        y_nxt_s    = y_r;
        act_nxt_s  = active_r;
        step_s     = {1'b0, x_r[idx_r]} + 12'(BULLET_SPEED);
        spawn_x_s  = {1'b0, ship_x} + 12'(SHIP_W);
        free_idx_s = {IDX_W{1'b0}};
        free_ok_s  = ~&active_r;
        for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
            free_idx_s = active_r[i] ? free_idx_s : IDX_W'(i);
        end
        spawn_ok_s = free_ok_s && (spawn_x_s < 12'(X_LIMIT));
        case (state_r)
            ST_UPDATE: begin
                if (active_r[idx_r]) begin
                    if (step_s >= 12'(X_LIMIT)) begin
                        act_nxt_s[idx_r] = 1'b0;
                    end else begin
                        x_nxt_s[idx_r] = step_s[10:0];
                    end
                end else begin
                    x_nxt_s[idx_r] = x_r[idx_r];
                end
            end
            ST_ALLOC: begin
                if (pend_r && spawn_ok_s) begin
                    x_nxt_s[free_idx_s]   = spawn_x_s[10:0];
                    y_nxt_s[free_idx_s]   = ship_y + 10'(SPAWN_DY);
                    act_nxt_s[free_idx_s] = 1'b1;
                end else begin
                    act_nxt_s = active_r;
                end
            end
            default: act_nxt_s = active_r;
        endcase
    end

    // Frame FSM, fire latch, bullet state and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            idx_r           <= {IDX_W{1'b0}};
            wcnt_r          <= {WCNT_W{1'b0}};
            for (int k = 0; k < MAX_BULLETS; k++) begin
                x_r[k] <= 11'd0;
                y_r[k] <= 10'd0;
            end
            active_r        <= {MAX_BULLETS{1'b0}};
            pend_r          <= 1'b0;
            av_write_r      <= 1'b0;
            av_address_r    <= 5'd0;
            av_writedata_r  <= 8'd0;
            busy_r          <= 1'b0;
            fire_dropped_r  <= 1'b0;
            frame_overrun_r <= 1'b0;
        end else begin
            x_r             <= x_nxt_s;
            y_r             <= y_nxt_s;
            active_r        <= act_nxt_s;
            // ALLOC consumes the pending shot; a fire in that same cycle pends for next frame.
            pend_r          <= (state_r == ST_ALLOC) ? fire : (pend_r | fire);
            fire_dropped_r  <= (fire && pend_r && (state_r != ST_ALLOC)) ||
                               ((state_r == ST_ALLOC) && pend_r && !spawn_ok_s);
            frame_overrun_r <= frame_tick && (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state_r <= ST_UPDATE;
                        idx_r   <= {IDX_W{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    if (idx_r == IDX_W'(MAX_BULLETS - 1)) begin
                        state_r <= ST_ALLOC;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_ALLOC: begin
                    state_r        <= ST_WRITE;
                    wcnt_r         <= {WCNT_W{1'b0}};
                    av_write_r     <= 1'b1;
                    av_address_r   <= 5'(BULLET_BASE);
                    av_writedata_r <= word_f({WCNT_W{1'b0}}, x_nxt_s, y_nxt_s, act_nxt_s);
                end
                ST_WRITE: begin
                    if (bus.bus_ready) begin
                        if (wcnt_r == WCNT_W'(N_WRITES - 1)) begin
                            state_r        <= ST_IDLE;
                            av_write_r     <= 1'b0;
                            av_address_r   <= 5'd0;
                            av_writedata_r <= 8'd0;
                            busy_r         <= 1'b0;
                        end else begin
                            wcnt_r         <= wcnt_r + WCNT_W'(1);
                            av_address_r   <= 5'(BULLET_BASE) + 5'(wcnt_r) + 5'd1;
                            av_writedata_r <= word_f(wcnt_r + WCNT_W'(1), x_r, y_r, active_r);
                        end
                    end else begin
                        state_r <= ST_WRITE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.av_write      = av_write_r;
    assign bus.av_chipselect = av_write_r;
    assign bus.av_address    = av_address_r;
    assign bus.av_writedata  = av_writedata_r;
    assign bullet_active     = active_r;
    assign busy              = busy_r;
    assign fire_dropped      = fire_dropped_r;
    assign frame_overrun     = frame_overrun_r;
endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: captures the written register image and
// checks it against hand-computed bullet positions.
module tb_bullet_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        fire = 1'b0;
    logic [10:0] ship_x = 11'd0;
    logic [9:0]  ship_y = 10'd0;
    logic [4:0]  bullet_active;
    logic        busy;
    logic        fire_dropped;
    logic        frame_overrun;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] img [32];
    int wr_total = 0;
    int wpos = 0;
    int seq_err = 0;
    int busy_total = 0;
    int drop_total = 0;
    int ovr_total = 0;

    bullet_scheduler_if bus ();

    bullet_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .fire          (fire),
        .ship_x        (ship_x),
        .ship_y        (ship_y),
        .bus           (bus),
        .bullet_active (bullet_active),
        .busy          (busy),
        .fire_dropped  (fire_dropped),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    // Bus monitor: captures accepted writes, checks address order, counts pulses.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wpos <= 0;
        end else begin
            if (bus.av_write && bus.bus_ready) begin
                img[bus.av_address] <= bus.av_writedata;
                wr_total <= wr_total + 1;
                if (bus.av_address != 5'(7 + wpos) || bus.av_chipselect != 1'b1)
                    seq_err <= seq_err + 1;
                wpos <= (wpos == 20) ? 0 : wpos + 1;
            end
            if (busy) busy_total <= busy_total + 1;
            if (fire_dropped) drop_total <= drop_total + 1;
            if (frame_overrun) ovr_total <= ovr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        logic done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = !busy;
        end
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_addr(input logic [4:0] a);
        logic found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            found = bus.av_write && (bus.av_address == a);
        end
        check("addr_timeout", 32'(found), 32'd1);
    endtask

    task automatic frame(input logic with_fire);
        @(negedge clk);
        frame_tick = 1'b1;
        fire = with_fire;
        @(negedge clk);
        frame_tick = 1'b0;
        fire = 1'b0;
        wait_idle();
    endtask

    function automatic logic [7:0] img_or();
        logic [7:0] acc = 8'd0;
        for (int a = 7; a <= 27; a++) acc = acc | img[a];
        return acc;
    endfunction

    initial begin
        int b0, w0, d0, o0;
        bus.bus_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_av_write", 32'(bus.av_write), 32'd0);
        check("rst_av_cs", 32'(bus.av_chipselect), 32'd0);
        check("rst_av_addr", 32'(bus.av_address), 32'd0);
        check("rst_av_data", 32'(bus.av_writedata), 32'd0);
        check("rst_bitmap", 32'(bullet_active), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({fire_dropped, frame_overrun}), 32'd0);
        reset = 1'b0;

        // Empty frame: 21 zero writes, busy for 27 cycles.
        for (int a = 0; a < 32; a++) img[a] = 8'hAA;
        b0 = busy_total; w0 = wr_total;
        frame(1'b0);
        check("empty_busy_cycles", 32'(busy_total - b0), 32'd27);
        check("empty_writes", 32'(wr_total - w0), 32'd21);
        check("empty_image", 32'(img_or()), 32'd0);

        // Single shot from ship (200,240): slot0 at (240,253).
        ship_x = 11'd200; ship_y = 10'd240;
        @(negedge clk); fire = 1'b1;
        @(negedge clk); fire = 1'b0;
        frame(1'b0);
        check("shot_x_lo", 32'(img[7]), 32'hF0);
        check("shot_x_hi", 32'(img[8]), 32'h00);
        check("shot_y_lo", 32'(img[9]), 32'hFD);
        check("shot_y_hi", 32'(img[10]), 32'h00);
        check("shot_bitmap", 32'(img[27]), 32'h01);
        frame(1'b0);
        check("move_x_lo", 32'(img[7]), 32'hF8);

        // Fill remaining slots, then a shot with no free slot is dropped.
        for (int f = 0; f < 4; f++) frame(1'b1);
        check("fill_bitmap", 32'(bullet_active), 32'h1F);
        check("fill_s1_x_lo", 32'(img[11]), 32'h08);
        check("fill_s1_x_hi", 32'(img[12]), 32'h01);
        check("fill_s4_x_lo", 32'(img[23]), 32'hF0);
        check("fill_s4_y_lo", 32'(img[25]), 32'hFD);
        d0 = drop_total;
        frame(1'b1);
        check("full_dropped", 32'(drop_total - d0), 32'd1);
        check("full_bitmap", 32'(img[27]), 32'h1F);

        // Retirement at the right edge, slot reuse and y wrap.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        ship_x = 11'd1235; ship_y = 10'd100;
        frame(1'b1);
        check("edge_x_lo", 32'(img[7]), 32'hFB);
        check("edge_x_hi", 32'(img[8]), 32'h04);
        frame(1'b0);
        check("retire_bitmap", 32'(img[27]), 32'h00);
        check("retire_x_kept", 32'(img[7]), 32'hFB);
        frame(1'b1);
        ship_x = 11'd100; ship_y = 10'd1020;
        frame(1'b1);
        check("reuse_bitmap", 32'(img[27]), 32'h01);
        check("reuse_x_lo", 32'(img[7]), 32'h8C);
        check("reuse_y_wrap", 32'(img[9]), 32'h09);
        check("reuse_y_hi", 32'(img[10]), 32'h00);
        ship_x = 11'd1240;
        d0 = drop_total;
        frame(1'b1);
        check("limit_dropped", 32'(drop_total - d0), 32'd1);
        check("limit_bitmap", 32'(bullet_active), 32'h01);

        // Back-pressure on the addr-9 write plus a frame_tick mid-burst.
        b0 = busy_total; w0 = wr_total; o0 = ovr_total;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        wait_addr(5'd9);
        bus.bus_ready = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("overrun_pulse", 32'(frame_overrun), 32'd1);
        check("stall_addr", 32'(bus.av_address), 32'd9);
        check("stall_data", 32'(bus.av_writedata), 32'h09);
        @(negedge clk);
        @(negedge clk);
        check("stall_hold", 32'({bus.av_write, bus.av_address, bus.av_writedata}), 32'({1'b1, 5'd9, 8'h09}));
        bus.bus_ready = 1'b1;
        wait_idle();
        check("stall_busy_cycles", 32'(busy_total - b0), 32'd30);
        check("stall_writes", 32'(wr_total - w0), 32'd21);
        check("overrun_count", 32'(ovr_total - o0), 32'd1);
        repeat (3) @(negedge clk);
        check("overrun_no_frame", 32'(busy), 32'd0);

        // Reset in the middle of a burst.
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        wait_addr(5'd15);
        reset = 1'b1;
        #1;
        check("abort_av_write", 32'(bus.av_write), 32'd0);
        check("abort_bitmap", 32'(bullet_active), 32'd0);
        @(negedge clk); reset = 1'b0;
        for (int a = 0; a < 32; a++) img[a] = 8'h55;
        w0 = wr_total;
        frame(1'b0);
        check("abort_writes", 32'(wr_total - w0), 32'd21);
        check("abort_image", 32'(img_or()), 32'd0);
        check("write_order", 32'(seq_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
